// File: rtl/tx_byte_fifo_if.sv
// Byte-stream bundle between the word-to-byte sender, the byte FIFO and the serial transmitter.
// Ports: wr_data/req_wr carry bytes in, rd_req pops, clear flushes; rd_data/rd_valid carry the popped
// byte out; full/empty/count report occupancy; overflow/underflow are sticky error flags.
interface tx_byte_fifo_if #(
  parameter int AW = 4
);
  logic [7:0]  wr_data;
  logic        req_wr;
  logic        rd_req;
  logic        clear;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        full;
  logic        empty;
  logic [AW:0] count;
  logic        overflow;
  logic        underflow;

  // Upstream/downstream agents drive requests and observe the FIFO outputs.
  modport master (
    output wr_data, req_wr, rd_req, clear,
    input  rd_data, rd_valid, full, empty, count, overflow, underflow
  );

  // The FIFO itself.
  modport slave (
    input  wr_data, req_wr, rd_req, clear,
    output rd_data, rd_valid, full, empty, count, overflow, underflow
  );
endinterface

// File: rtl/tx_byte_fifo.sv
// Byte FIFO between the word-to-byte sender and the serial transmitter.
// Latency: accepted rd_req -> registered rd_data with rd_valid one cycle later.
// Backpressure: writes while full and reads while empty are dropped and flagged sticky.
// Ports: clock, reset (async, active high); bus (slave modport) carries wr_data/req_wr in,
// rd_req/clear controls, rd_data/rd_valid out, full/empty/count status, overflow/underflow flags.
module tx_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic           clock,
  input  logic           reset,
  tx_byte_fifo_if.slave  bus
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  // Storage: never reset, only written on an accepted write.
  logic [7:0]    mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q,    wr_ptr_d;
  logic [AW-1:0] rd_ptr_q,    rd_ptr_d;
  logic [AW:0]   count_q,     count_d;
  logic          full_q,      full_d;
  logic          empty_q,     empty_d;
  logic [7:0]    rd_data_q,   rd_data_d;
  logic          rd_valid_q,  rd_valid_d;
  logic          overflow_q,  overflow_d;
  logic          underflow_q, underflow_d;

  logic          wr_accept;
  logic          rd_accept;

  // Acceptance is judged on the registered flags from the start of the cycle, so a
  // write while full is rejected even if a read frees a slot in the same cycle, and a
  // read while empty is rejected even if a write lands in the same cycle.
  always_comb begin
    wr_accept = bus.req_wr && !full_q  && !bus.clear;
    rd_accept = bus.rd_req && !empty_q && !bus.clear;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (bus.clear) begin
      // Flush bookkeeping only; rd_data and memory keep their contents.
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_accept) begin
        rd_ptr_d   = rd_ptr_q + AW'(1);
        rd_data_d  = mem_q[rd_ptr_q];
        rd_valid_d = 1'b1;
      end
      unique case ({wr_accept, rd_accept})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
      if (bus.req_wr && full_q) begin
        overflow_d = 1'b1;
      end
      if (bus.rd_req && empty_q) begin
        underflow_d = 1'b1;
      end
    end

    // Status flags come from the next count so they line up with count itself.
    full_d  = (count_d == DEPTH_CNT);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      rd_data_q   <= 8'h00;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Reset cannot block this write: wr_accept already requires !full_q and the
  // pointer is held at 0 during reset, so a write during reset is harmless
  // only if it is never made; gate it explicitly.
  always_ff @(posedge clock) begin
    if (wr_accept && !reset) begin
      mem_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_tx_byte_fifo.sv
// Self-checking bench for tx_byte_fifo: directed scenarios followed by random traffic,
// all compared against a queue-based reference model.
module tb_tx_byte_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clock;
  logic reset;

  tx_byte_fifo_if #(.AW(AW)) bus ();

  tx_byte_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [7:0] m_q[$];
  logic [7:0] m_rdd;
  logic       m_rv;
  logic       m_ovf;
  logic       m_unf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_rdd = 8'h00;
    m_rv  = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // One clock of the FIFO's behaviour, stated from the rules on occupancy.
  task automatic model_step(input logic w, input logic r, input logic c, input logic [7:0] d);
    bit was_full;
    bit was_empty;
    was_full  = (m_q.size() == DEPTH);
    was_empty = (m_q.size() == 0);
    m_rv = 1'b0;
    if (c) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (r) begin
        if (was_empty) m_unf = 1'b1;
        else begin
          m_rdd = m_q.pop_front();
          m_rv  = 1'b1;
        end
      end
      if (w) begin
        if (was_full) m_ovf = 1'b1;
        else m_q.push_back(d);
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"},     32'(bus.count),     32'(m_q.size()));
    chk({tag, ".full"},      32'(bus.full),      32'(m_q.size() == DEPTH));
    chk({tag, ".empty"},     32'(bus.empty),     32'(m_q.size() == 0));
    chk({tag, ".rd_valid"},  32'(bus.rd_valid),  32'(m_rv));
    chk({tag, ".rd_data"},   32'(bus.rd_data),   32'(m_rdd));
    chk({tag, ".overflow"},  32'(bus.overflow),  32'(m_ovf));
    chk({tag, ".underflow"}, 32'(bus.underflow), 32'(m_unf));
  endtask

  // Apply inputs for one cycle, then sample 1 time unit after the edge.
  task automatic cycle(input string tag, input logic w, input logic r, input logic c,
                       input logic [7:0] d);
    bus.req_wr  = w;
    bus.rd_req  = r;
    bus.clear   = c;
    bus.wr_data = d;
    @(posedge clock);
    #1;
    model_step(w, r, c, d);
    bus.req_wr = 1'b0;
    bus.rd_req = 1'b0;
    bus.clear  = 1'b0;
    check_all(tag);
  endtask

  initial begin
    logic [7:0] pat [4];
    int max_cnt;
    pat[0] = 8'h44; pat[1] = 8'h33; pat[2] = 8'h22; pat[3] = 8'h11;

    reset       = 1'b1;
    bus.req_wr  = 1'b0;
    bus.rd_req  = 1'b0;
    bus.clear   = 1'b0;
    bus.wr_data = 8'h00;
    model_reset();
    #2;
    check_all("reset");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_all("post_reset");

    // Four bytes in with gaps, then four pops.
    for (int i = 0; i < 4; i++) begin
      cycle("wr4", 1'b1, 1'b0, 1'b0, pat[i]);
      cycle("wr4_gap", 1'b0, 1'b0, 1'b0, 8'h00);
    end
    chk("wr4_count", 32'(bus.count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      cycle("rd4", 1'b0, 1'b1, 1'b0, 8'h00);
      chk("rd4_byte", 32'(bus.rd_data), 32'(pat[i]));
      chk("rd4_valid", 32'(bus.rd_valid), 32'd1);
    end
    cycle("rd4_idle", 1'b0, 1'b0, 1'b0, 8'h00);
    chk("rd4_empty", 32'(bus.empty), 32'd1);

    // Fill, overfill, drain.
    for (int i = 0; i < 16; i++) cycle("fill", 1'b1, 1'b0, 1'b0, 8'(i));
    cycle("overfill", 1'b1, 1'b0, 1'b0, 8'hAA);
    chk("overfill_full", 32'(bus.full), 32'd1);
    chk("overfill_count", 32'(bus.count), 32'd16);
    chk("overfill_flag", 32'(bus.overflow), 32'd1);
    for (int i = 0; i < 16; i++) begin
      cycle("drain", 1'b0, 1'b1, 1'b0, 8'h00);
      chk("drain_byte", 32'(bus.rd_data), 32'(i));
    end
    cycle("drain_extra", 1'b0, 1'b1, 1'b0, 8'h00);
    chk("drain_no_aa", 32'(bus.rd_valid), 32'd0);

    // Simultaneous write+read while full.
    cycle("clr1", 1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 16; i++) cycle("fill2", 1'b1, 1'b0, 1'b0, 8'(i));
    cycle("wr_rd_full", 1'b1, 1'b1, 1'b0, 8'hBB);
    chk("wrrd_full_valid", 32'(bus.rd_valid), 32'd1);
    chk("wrrd_full_data", 32'(bus.rd_data), 32'h00);
    chk("wrrd_full_count", 32'(bus.count), 32'd15);
    chk("wrrd_full_ovf", 32'(bus.overflow), 32'd1);

    // Read while empty, then clear.
    cycle("clr2", 1'b0, 1'b0, 1'b1, 8'h00);
    cycle("rd_empty", 1'b0, 1'b1, 1'b0, 8'h00);
    chk("rd_empty_valid", 32'(bus.rd_valid), 32'd0);
    chk("rd_empty_unf", 32'(bus.underflow), 32'd1);
    cycle("clr3", 1'b0, 1'b0, 1'b1, 8'h00);
    chk("clr_unf", 32'(bus.underflow), 32'd0);
    chk("clr_count", 32'(bus.count), 32'd0);

    // Simultaneous write+read while empty.
    cycle("wr_rd_empty", 1'b1, 1'b1, 1'b0, 8'h77);
    chk("wrrd_empty_count", 32'(bus.count), 32'd1);
    chk("wrrd_empty_valid", 32'(bus.rd_valid), 32'd0);
    chk("wrrd_empty_unf", 32'(bus.underflow), 32'd1);
    cycle("clr4", 1'b0, 1'b0, 1'b1, 8'h00);

    // 40 write/read pairs, pointers wrap twice.
    max_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cycle("pair_wr", 1'b1, 1'b0, 1'b0, 8'(i));
      if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
      cycle("pair_rd", 1'b0, 1'b1, 1'b0, 8'h00);
      chk("pair_byte", 32'(bus.rd_data), 32'(i));
    end
    chk("pair_max_count", 32'(max_cnt), 32'd1);

    // Asynchronous reset mid-burst.
    for (int i = 0; i < 3; i++) cycle("pre_rst", 1'b1, 1'b0, 1'b0, 8'(8'hC0 + i));
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    chk("async_rst_count", 32'(bus.count), 32'd0);
    chk("async_rst_empty", 32'(bus.empty), 32'd1);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    cycle("post_rst_wr", 1'b1, 1'b0, 1'b0, 8'h5A);
    cycle("post_rst_rd", 1'b0, 1'b1, 1'b0, 8'h00);
    chk("post_rst_byte", 32'(bus.rd_data), 32'h5A);

    // Random traffic with alternating fill-biased and drain-biased phases.
    for (int ph = 0; ph < 12; ph++) begin
      for (int i = 0; i < 60; i++) begin
        logic w, r, c;
        w = ($urandom_range(99) < ((ph % 2 == 0) ? 75 : 30));
        r = ($urandom_range(99) < ((ph % 2 == 0) ? 30 : 75));
        c = ($urandom_range(199) == 0);
        cycle("rand", w, r, c, 8'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_byte_fifo.md
TX_BYTE_FIFO -- requirements
Module: tx_byte_fifo

Interface
REQ-001 Parameter DEPTH, default 16, SHALL set the number of byte entries (power of two, 4..256).
REQ-002 Parameter AW, default 4, SHALL equal log2(DEPTH) and size the pointers.
REQ-003 Port clock, input, 1, SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1, SHALL be the asynchronous, active-high reset.
REQ-005 Port wr_data, input, 8, SHALL carry the byte from the upstream word-to-byte sender.
REQ-006 Port req_wr, input, 1, SHALL request a write of wr_data; each high cycle is one byte.
REQ-007 Port rd_req, input, 1, SHALL request a pop from the downstream serial transmitter.
REQ-008 Port clear, input, 1, SHALL synchronously flush the FIFO.
REQ-009 Port rd_data, output, 8, SHALL be the registered popped byte.
REQ-010 Port rd_valid, output, 1, SHALL pulse high for one cycle when rd_data holds a newly popped byte.
REQ-011 Port full, output, 1, SHALL be high when count equals DEPTH.
REQ-012 Port empty, output, 1, SHALL be high when count equals 0.
REQ-013 Port count, output, AW+1, SHALL be the number of stored bytes.
REQ-014 Port overflow, output, 1, SHALL be a sticky flag: a write was attempted while full.
REQ-015 Port underflow, output, 1, SHALL be a sticky flag: a read was attempted while empty.

Function
REQ-016 Write accept: req_wr=1 and full=0; wr_data SHALL be stored at wr_ptr, and wr_ptr SHALL advance by 1 modulo DEPTH.
REQ-017 Read accept: rd_req=1 and empty=0; mem[rd_ptr] SHALL load into rd_data, rd_valid SHALL be 1 next cycle, and rd_ptr SHALL advance modulo DEPTH.
REQ-018 Read latency SHALL be exactly 1 cycle from the accepted rd_req edge to rd_valid=1.
REQ-019 rd_data SHALL hold its last value when no read is accepted; rd_valid SHALL be 0 otherwise.
REQ-020 Bytes SHALL leave in write order, so a 32-bit word sent LSB-first leaves LSB-first.
REQ-021 count SHALL be +1 on write-only, -1 on read-only, and unchanged on both or neither.
REQ-022 Simultaneous write and read while full: the read SHALL be accepted, the write SHALL be rejected, overflow SHALL be set, and count SHALL become DEPTH-1.
REQ-023 Simultaneous write and read while empty: the write SHALL be accepted, the read SHALL be rejected, underflow SHALL be set, rd_valid SHALL be 0, and count SHALL become 1.
REQ-024 A rejected write SHALL leave the memory and pointers unchanged; a rejected read SHALL leave rd_data, rd_ptr and count unchanged.
REQ-025 Pointer wrap from DEPTH-1 to 0 SHALL be seamless, with no lost or duplicated byte.
REQ-026 full and empty SHALL be registered and derived from the next count value, so they are valid in the same cycle as count.
REQ-027 clear=1 SHALL take priority over req_wr and rd_req: pointers and count SHALL go to 0, empty=1, full=0, rd_valid=0, and overflow/underflow SHALL be cleared.
REQ-028 clear SHALL NOT alter rd_data or memory contents.
REQ-029 overflow and underflow SHALL remain set until reset or clear.

Reset
REQ-030 While reset=1, independent of clock: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, rd_valid=0, rd_data=8'h00, overflow=0, underflow=0.
REQ-031 Memory contents SHALL NOT require reset.
REQ-032 Reset asserted mid-burst SHALL discard all stored bytes; the first write after release SHALL be stored at index 0.
REQ-033 Deassertion SHALL take effect only at a rising clock edge; no write or read SHALL be accepted in the deassertion cycle's edge while reset=1.

Verification
REQ-034 Write 8'h44,8'h33,8'h22,8'h11 via 1-cycle req_wr pulses spaced 2 cycles, then rd_req x4 -> rd_data 44,33,22,11 each with rd_valid one cycle later; count 4->0; empty=1.
REQ-035 Write 16 bytes 00..0F, then write 8'hAA -> full=1, count=16, overflow=1; reading 16 times returns 00..0F and no AA.
REQ-036 With the FIFO full, req_wr=1 and rd_req=1 in the same cycle -> rd_valid=1 next cycle with 8'h00, count=15, overflow=1.
REQ-037 With the FIFO empty, rd_req=1 -> rd_valid stays 0, underflow=1; then clear=1 for one cycle -> underflow=0, count=0.
REQ-038 Repeat 40 write/read pairs with values 0..39 (pointer wrap twice) -> output sequence 0..39 exact, count never exceeds 1.
REQ-039 Write 3 bytes, assert reset asynchronously between edges -> count=0 and empty=1 immediately; after release, write 8'h5A and read -> 8'h5A.
